// File: rtl/tiny_pkg.sv
// Shared definitions for the tiny memory controller: FSM encoding, parameter
// range limits and the bank-select width helper.
package tiny_pkg;

  localparam int MIN_BANKS       = 1;
  localparam int MAX_BANKS       = 16;
  localparam int MAX_WAIT_STATES = 15;
  localparam int CNT_W           = $clog2(MAX_WAIT_STATES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int sel_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/tiny_mem_bank.sv
// One memory bank: synchronous-write word array with a registered read port.
// The array itself is never reset; only the read register is.
module tiny_mem_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rdata_q <= '0;
    else if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tiny_mem_ctrl.sv
// Multi-bank memory controller with programmable wait states, per-bank write
// protection and a one-access-at-a-time IDLE -> WAIT -> DONE handshake.
module tiny_mem_ctrl
  import tiny_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int BANKS       = 2,
  parameter int WAIT_STATES = 1,
  localparam int SEL_W      = sel_width(BANKS)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [SEL_W-1:0]  bank,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BANKS-1:0]  wprot,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [SEL_W:0] BANKS_LIM = (SEL_W + 1)'(BANKS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  bank_q, bank_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  rd_bank_q, rd_bank_d;

  logic              req, bad_bank, prot_hit, reject, accept, finish;
  logic [BANKS-1:0]  bank_we, bank_re;
  logic [DATA_W-1:0] bank_rdata [BANKS];

  // Request qualification; wprot is only looked at here, so changes during WAIT are ignored.
  always_comb begin
    bad_bank = ({1'b0, bank} >= BANKS_LIM);
    prot_hit = 1'b0;
    for (int i = 0; i < BANKS; i++) begin
      if (bank == SEL_W'(i)) prot_hit = wprot[i];
    end
    req    = read | write;
    reject = (state_q == ST_IDLE) && req &&
             ((read && write) || bad_bank || (write && prot_hit));
    accept = (state_q == ST_IDLE) && req && !reject;
    finish = (state_q == ST_WAIT) && (cnt_q == '0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rd_bank_d  = rd_bank_q;
    err_d      = reject;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_WAIT;
          cnt_d      = CNT_W'(WAIT_STATES);
          addr_d     = addr;
          bank_d     = bank;
          wdata_d    = wdata;
          is_write_d = write;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!is_write_q) rd_bank_d = bank_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      bank_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Bank strobes fire only on the edge that enters DONE.
  always_comb begin
    bank_we = '0;
    bank_re = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (finish && (bank_q == SEL_W'(i))) begin
        bank_we[i] = is_write_q;
        bank_re[i] = !is_write_q;
      end
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    tiny_mem_bank #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk   (clk),
      .nreset(nreset),
      .we    (bank_we[g]),
      .re    (bank_re[g]),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (bank_rdata[g])
    );
  end

  // Each bank's read register only moves on its own reads, so showing the last-read bank holds rdata.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (rd_bank_q == SEL_W'(i)) rdata = bank_rdata[i];
    end
  end

  assign ready = (state_q == ST_DONE);
  assign busy  = (state_q != ST_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_tiny_mem_ctrl.sv
// Directed self-checking bench for tiny_mem_ctrl: a default instance and a
// BANKS=3 / WAIT_STATES=3 instance.
module tb_tiny_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nreset, read, write, bank;
  logic [7:0] addr, wdata, rdata;
  logic [1:0] wprot;
  logic       ready, busy, err;

  logic       nreset3, read3, write3;
  logic [1:0] bank3;
  logic [7:0] addr3, wdata3, rdata3;
  logic [2:0] wprot3;
  logic       ready3, busy3, err3;

  int n_checks = 0;
  int n_fail   = 0;

  tiny_mem_ctrl u_dut (
    .clk   (clk),
    .nreset(nreset),
    .read  (read),
    .write (write),
    .addr  (addr),
    .bank  (bank),
    .wdata (wdata),
    .wprot (wprot),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  tiny_mem_ctrl #(
    .BANKS      (3),
    .WAIT_STATES(3)
  ) u_dut3 (
    .clk   (clk),
    .nreset(nreset3),
    .read  (read3),
    .write (write3),
    .addr  (addr3),
    .bank  (bank3),
    .wdata (wdata3),
    .wprot (wprot3),
    .rdata (rdata3),
    .ready (ready3),
    .busy  (busy3),
    .err   (err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic sel,
                               input logic [7:0] a, input logic [7:0] d, input logic [1:0] prot);
    read  = rd;
    write = wr;
    bank  = sel;
    addr  = a;
    wdata = d;
    wprot = prot;
  endtask

  // Full accepted access on the default instance (WAIT_STATES=1): ready 2 edges after acceptance.
  task automatic runAccess(input string tag, input logic rd, input logic wr, input logic sel,
                           input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    applyStimulus(rd, wr, sel, a, d, 2'b00);
    tick();
    checkOutput({tag, "_busy_acc"}, busy, 1);
    checkOutput({tag, "_ready_acc"}, ready, 0);
    applyStimulus(1'b0, 1'b0, ~sel, ~a, ~d, 2'b11);
    for (int j = 1; j <= 2; j++) begin
      tick();
      checkOutput({tag, "_ready_wait"}, ready, (j == 2));
      checkOutput({tag, "_busy_wait"}, busy, 1);
      checkOutput({tag, "_err_wait"}, err, 0);
    end
    checkOutput({tag, "_rdata"}, rdata, exp_rd);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    checkOutput({tag, "_ready_end"}, ready, 0);
    checkOutput({tag, "_busy_end"}, busy, 0);
  endtask

  // Same for the BANKS=3 / WAIT_STATES=3 instance: ready 4 edges after acceptance.
  task automatic runAccess3(input string tag, input logic rd, input logic wr, input logic [1:0] sel,
                            input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    read3 = rd; write3 = wr; bank3 = sel; addr3 = a; wdata3 = d; wprot3 = 3'b000;
    tick();
    checkOutput({tag, "_busy_acc"}, busy3, 1);
    read3 = 1'b0; write3 = 1'b0; bank3 = ~sel; addr3 = ~a; wdata3 = ~d; wprot3 = 3'b111;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checkOutput({tag, "_ready_wait"}, ready3, (j == 4));
      checkOutput({tag, "_busy_wait"}, busy3, 1);
    end
    checkOutput({tag, "_rdata"}, rdata3, exp_rd);
    wprot3 = 3'b000;
    tick();
    checkOutput({tag, "_busy_end"}, busy3, 0);
  endtask

  initial begin
    nreset = 1'b0; nreset3 = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    read3 = 1'b0; write3 = 1'b0; bank3 = 2'd0; addr3 = 8'h00; wdata3 = 8'h00; wprot3 = 3'b000;
    #1;
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdata3", rdata3, 0);
    checkOutput("rst_busy3", busy3, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1; nreset3 = 1'b1;

    runAccess("wr_b1_10", 1'b0, 1'b1, 1'b1, 8'h10, 8'h5a, 8'h00);
    runAccess("rd_b1_10", 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'h5a);
    runAccess("wr_b0_03", 1'b0, 1'b1, 1'b0, 8'h03, 8'h11, 8'h5a);
    runAccess("wr_b1_03", 1'b0, 1'b1, 1'b1, 8'h03, 8'h22, 8'h5a);
    runAccess("rd_b0_03", 1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 8'h11);
    runAccess("rd_b1_03", 1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 8'h22);
    runAccess("rd_b1_10_again", 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'h5a);
    runAccess("wr_b0_00", 1'b0, 1'b1, 1'b0, 8'h00, 8'h3c, 8'h5a);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'hff, 2'b01);
    tick();
    checkOutput("prot_err", err, 1);
    checkOutput("prot_busy", busy, 0);
    checkOutput("prot_ready", ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01);
    tick();
    checkOutput("prot_err_clear", err, 0);
    checkOutput("prot_busy_after", busy, 0);
    checkOutput("prot_rdata_hold", rdata, 8'h5a);
    runAccess("rd_b0_00", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3c);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 2'b00);
    tick();
    checkOutput("rw_err", err, 1);
    checkOutput("rw_busy", busy, 0);
    checkOutput("rw_ready", ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    checkOutput("rw_err_clear", err, 0);
    checkOutput("rw_rdata_hold", rdata, 8'h3c);

    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 2'b00);
    for (int j = 1; j <= 8; j++) begin
      tick();
      checkOutput("b2b_ready", ready, ((j % 4) == 3));
      checkOutput("b2b_busy", busy, ((j % 4) != 0));
      if ((j % 4) == 3) checkOutput("b2b_rdata", rdata, 8'h5a);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    tick();
    checkOutput("b2b_idle", busy, 0);

    read3 = 1'b1; bank3 = 2'd3;
    tick();
    checkOutput("bank3_err", err3, 1);
    checkOutput("bank3_busy", busy3, 0);
    read3 = 1'b0; bank3 = 2'd0;
    tick();
    checkOutput("bank3_err_clear", err3, 0);

    runAccess3("w3_b2_05", 1'b0, 1'b1, 2'd2, 8'h05, 8'ha5, 8'h00);
    runAccess3("r3_b2_05", 1'b1, 1'b0, 2'd2, 8'h05, 8'h00, 8'ha5);

    write3 = 1'b1; bank3 = 2'd2; addr3 = 8'h05; wdata3 = 8'h3c;
    tick();
    checkOutput("abort_busy_acc", busy3, 1);
    write3 = 1'b0;
    tick();
    #2;
    nreset3 = 1'b0;
    #1;
    checkOutput("abort_busy", busy3, 0);
    checkOutput("abort_ready", ready3, 0);
    checkOutput("abort_err", err3, 0);
    checkOutput("abort_rdata", rdata3, 0);
    read3 = 1'b1; bank3 = 2'd2; addr3 = 8'h05;
    #2;
    nreset3 = 1'b1;
    tick();
    checkOutput("first_edge_accept", busy3, 1);
    read3 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checkOutput("after_abort_ready", ready3, (j == 4));
    end
    checkOutput("after_abort_rdata", rdata3, 8'ha5);
    tick();
    checkOutput("after_abort_idle", busy3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
